bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system bus between the camera grabber DMA and the other bus masters (CPU data cache, display controller, etc.). It takes each master's requestBus, returns a one-hot busGrant, tracks the transaction framing (beginTransaction/endTransaction/busError) to decide when the bus is free, and enforces a watchdog so a stuck master cannot lock the bus. It sits between the masters' request/grant pins and the bus, next to the OR-combined transaction signals.

---
 rtl/bus_arbiter_if.sv | 25 ++
 rtl/bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Request/grant and transaction-framing signals shared between the bus masters and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/bus side.
interface bus_arbiter_if #(
  parameter int nrOfMasters = 4
);
  logic [nrOfMasters-1:0] requests;
  logic [nrOfMasters-1:0] grants;
  logic                   beginTransactionIn;
  logic                   endTransactionIn;
  logic                   busErrorIn;
  logic                   arbEndTransactionOut;
  logic                   arbBusErrorOut;
  logic [2:0]             activeMaster;
  logic                   busIdle;

  modport slave (
    input  requests, beginTransactionIn, endTransactionIn, busErrorIn,
    output grants, arbEndTransactionOut, arbBusErrorOut, activeMaster, busIdle
  );

  modport master (
    output requests, beginTransactionIn, endTransactionIn, busErrorIn,
    input  grants, arbEndTransactionOut, arbBusErrorOut, activeMaster, busIdle
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter with transaction tracking and a watchdog that
// forces a release (with bus error / end pulses) when a grantee stalls.
module bus_arbiter #(
  parameter int nrOfMasters   = 4,
  parameter int timeoutCycles = 1024
) (
  input logic          clock,
  input logic          reset,
  bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(timeoutCycles + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(timeoutCycles - 1);
  localparam logic [2:0] LAST_IDX = 3'(nrOfMasters - 1);
  localparam logic [3:0] NR_MASTERS = 4'(nrOfMasters);
  localparam logic [nrOfMasters-1:0] GRANT_LSB = {{(nrOfMasters-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [nrOfMasters-1:0] grants_q, grants_d;
  logic [2:0]             active_q, active_d;
  logic [2:0]             pointer_q, pointer_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   arb_end_q, arb_end_d;
  logic                   arb_err_q, arb_err_d;
  logic                   bus_idle_q, bus_idle_d;

  logic [2*nrOfMasters-1:0] dbl_s;
  logic [nrOfMasters-1:0]   rot_s;
  logic                     found_s;
  logic [3:0]               offset_s;
  logic [3:0]               sum_s;
  logic [2:0]               winner_s;
  logic                     expire_s;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit, then map back
  always_comb begin
    dbl_s    = {bus.requests, bus.requests};
    rot_s    = nrOfMasters'(dbl_s >> pointer_q);
    found_s  = 1'b0;
    offset_s = 4'd0;
    for (int j = 0; j < nrOfMasters; j++) begin
      if (!found_s && rot_s[j]) begin
        found_s  = 1'b1;
        offset_s = 4'(j);
      end else begin
        found_s  = found_s;
      end
    end
    sum_s = {1'b0, pointer_q} + offset_s;
    if (sum_s >= NR_MASTERS) begin
      winner_s = 3'(sum_s - NR_MASTERS);
    end else begin
      winner_s = 3'(sum_s);
    end
  end

  // Next-state decisions; an end/error or begin in the expiry cycle beats the watchdog
  always_comb begin
    state_d   = state_q;
    grants_d  = grants_q;
    active_d  = active_q;
    pointer_d = pointer_q;
    count_d   = count_q + CW'(1);
    arb_end_d = 1'b0;
    arb_err_d = 1'b0;
    expire_s  = (count_q == LAST_COUNT);
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (found_s) begin
          state_d  = GRANTED;
          grants_d = GRANT_LSB << winner_s;
          active_d = winner_s;
        end else begin
          grants_d = '0;
        end
      end
      GRANTED: begin
        if (bus.beginTransactionIn) begin
          state_d = BUSY;
          count_d = '0;
        end else if (expire_s) begin
          state_d   = RELEASE;
          grants_d  = '0;
          count_d   = '0;
          arb_err_d = 1'b1;
        end else begin
          state_d = GRANTED;
        end
      end
      BUSY: begin
        if (bus.endTransactionIn || bus.busErrorIn) begin
          state_d  = RELEASE;
          grants_d = '0;
          count_d  = '0;
        end else if (expire_s) begin
          state_d   = RELEASE;
          grants_d  = '0;
          count_d   = '0;
          arb_end_d = 1'b1;
          arb_err_d = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        grants_d = '0;
        count_d  = '0;
        if (active_q == LAST_IDX) begin
          pointer_d = 3'd0;
        end else begin
          pointer_d = active_q + 3'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        grants_d = '0;
        count_d  = '0;
      end
    endcase
    bus_idle_d = (state_d == IDLE);
  end

  // Arbiter state and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grants_q   <= '0;
      active_q   <= 3'd0;
      pointer_q  <= 3'd0;
      count_q    <= '0;
      arb_end_q  <= 1'b0;
      arb_err_q  <= 1'b0;
      bus_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      grants_q   <= grants_d;
      active_q   <= active_d;
      pointer_q  <= pointer_d;
      count_q    <= count_d;
      arb_end_q  <= arb_end_d;
      arb_err_q  <= arb_err_d;
      bus_idle_q <= bus_idle_d;
    end
  end

  assign bus.grants               = grants_q;
  assign bus.activeMaster         = active_q;
  assign bus.arbEndTransactionOut = arb_end_q;
  assign bus.arbBusErrorOut       = arb_err_q;
  assign bus.busIdle              = bus_idle_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each episode predicts grant/release/pulse/idle events
// from round-robin rules and watchdog timing; a negedge monitor matches DUT events to them.
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int T = 8;
  localparam int K_GRANT = 0;
  localparam int K_DROP  = 1;
  localparam int K_PULSE = 2;
  localparam int K_IDLE  = 3;

  typedef struct {
    int kind;
    int val;
    int am;
    int cyc;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  int   ptr_m = 0;
  int   idle_at = 0;
  logic mon_en = 1'b0;

  bus_arbiter_if #(.nrOfMasters(N)) bus ();

  bus_arbiter #(.nrOfMasters(N), .timeoutCycles(T)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (((req >> ((ptr + k) % N)) & 4'd1) != 4'd0) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) begin
      if (g == (4'd1 << k)) return k;
    end
    return -1;
  endfunction

  function automatic void push_ev(input int kind, input int val, input int am, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.am = am; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic cmp(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic observe(input int kind, input int val, input int am);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d val=%0d am=%0d cycle=%0d required=no event", kind, val, am, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.am != am || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event got kind=%0d val=%0d am=%0d cycle=%0d required kind=%0d val=%0d am=%0d cycle=%0d",
                 kind, val, am, cyc, e.kind, e.val, e.am, e.cyc);
      end
    end
  endtask

  // Monitor: turn DUT output changes into events and check them against the scoreboard
  initial begin
    logic [N-1:0] prev_g;
    logic         prev_idle;
    ev_t          e;
    prev_g    = '0;
    prev_idle = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          n_vec++;
          n_fail++;
          $display("FAIL missing_event kind=%0d val=%0d required at cycle=%0d, not seen by cycle=%0d", e.kind, e.val, e.cyc, cyc);
        end
        if (bus.grants != prev_g && bus.grants != '0)
          observe(K_GRANT, oh_idx(bus.grants), int'(bus.activeMaster));
        if (bus.grants == '0 && prev_g != '0)
          observe(K_DROP, oh_idx(prev_g), int'(bus.activeMaster));
        if (bus.arbEndTransactionOut || bus.arbBusErrorOut)
          observe(K_PULSE, int'({bus.arbEndTransactionOut, bus.arbBusErrorOut}), int'(bus.activeMaster));
        if (bus.busIdle && !prev_idle)
          observe(K_IDLE, 0, int'(bus.activeMaster));
        prev_g    = bus.grants;
        prev_idle = bus.busIdle;
      end
    end
  end

  task automatic drive(input logic [N-1:0] req, input logic b, input logic e, input logic er, input logic rst);
    bus.requests           = req;
    bus.beginTransactionIn = b;
    bus.endTransactionIn   = e;
    bus.busErrorIn         = er;
    reset                  = rst;
    @(posedge clock);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // kind: 0 end, 1 bus error, 2 no begin (grant timeout), 3 no end (busy timeout)
  task automatic episode(input logic [N-1:0] req, input int kind, input int g, input int d, input int gap);
    int   w, c, bcy, rel;
    logic b, e, er;
    while (cyc < idle_at) drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) drive('0, rbit(), rbit(), rbit(), 1'b0);
    c   = cyc;
    w   = rr_pick(req, ptr_m);
    bcy = c + 1 + g;
    if (kind == 2)      rel = c + 1 + T;
    else if (kind == 3) rel = bcy + 1 + T;
    else                rel = bcy + 2 + d;
    push_ev(K_GRANT, w, w, c + 1);
    push_ev(K_DROP, w, w, rel);
    if (kind == 2) push_ev(K_PULSE, 1, w, rel);
    if (kind == 3) push_ev(K_PULSE, 3, w, rel);
    push_ev(K_IDLE, 0, w, rel + 1);
    drive(req, 1'b0, 1'b0, 1'b0, 1'b0);
    while (cyc < rel) begin
      if (kind == 2 || cyc < bcy) begin
        b = 1'b0; e = rbit(); er = rbit();
      end else if (cyc == bcy) begin
        b = 1'b1; e = rbit(); er = rbit();
      end else begin
        b = rbit(); e = 1'b0; er = 1'b0;
        if (kind == 0 && cyc == rel - 1) begin e = 1'b1; er = rbit(); end
        if (kind == 1 && cyc == rel - 1) er = 1'b1;
      end
      drive(N'($urandom), b, e, er, 1'b0);
    end
    drive(N'($urandom), rbit(), rbit(), rbit(), 1'b0);
    ptr_m   = (w + 1) % N;
    idle_at = rel + 1;
  endtask

  task automatic reset_episode(input logic [N-1:0] req);
    int c, w, r;
    while (cyc < idle_at) drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    c = cyc;
    w = rr_pick(req, ptr_m);
    r = c + 4;
    push_ev(K_GRANT, w, w, c + 1);
    push_ev(K_DROP, w, 0, r + 1);
    push_ev(K_IDLE, 0, 0, r + 1);
    drive(req, 1'b0, 1'b0, 1'b0, 1'b0);
    drive('0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b1, 1'b1, 1'b1);
    ptr_m   = 0;
    idle_at = r + 1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("reset_grants", int'(bus.grants), 0);
    cmp("reset_arb_end", int'(bus.arbEndTransactionOut), 0);
    cmp("reset_arb_err", int'(bus.arbBusErrorOut), 0);
    cmp("reset_active_master", int'(bus.activeMaster), 0);
    cmp("reset_bus_idle", int'(bus.busIdle), 1);
    mon_en  = 1'b1;
    idle_at = cyc;

    // rotation from pointer 0, then skip over idle requesters, then timeouts and collisions
    for (int i = 0; i < 5; i++) episode(4'b1111, 0, 0, 5, 0);
    episode(4'b1001, 0, 1, 2, 0);
    episode(4'b1001, 1, 0, 3, 1);
    episode(4'b0100, 0, 0, 5, 2);
    episode(4'b0010, 2, 0, 0, 0);
    episode(4'b0001, 3, 2, 0, 0);
    episode(4'b1000, 0, 1, T - 1, 0);
    episode(4'b0100, 0, T - 1, 1, 0);
    episode(4'b0010, 1, 0, T - 1, 0);
    reset_episode(4'b1000);
    episode(4'b0110, 0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      if (i == 40) reset_episode(N'($urandom_range(1, 15)));
      episode(N'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, T - 1)), int'($urandom_range(0, T - 1)),
              int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 4; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
